// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches words over a req/ack handshake,
// presents the instruction to decode and computes the next PC on consumption.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  op_c,
   output logic        instr_valid,
   input  logic        advance,
   input  logic        branch,
   input  logic        zero,
   input  logic        j_c,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr_count
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned OPW  = 6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic [XLEN-1:0]   count_q, count_d;
   logic              req_q, req_d;
   logic              valid_q, valid_d;

   logic [XLEN-1:0]   pc_plus4_w;
   logic [XLEN-1:0]   br_off_w;
   logic [XLEN-1:0]   jmp_tgt_w;
   logic [XLEN-1:0]   next_pc_w;

   // Next-PC candidates, all relative to the instruction currently held
   assign pc_plus4_w = pc_q + XLEN'(4);
   assign br_off_w   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign jmp_tgt_w  = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};

   always_comb begin
      next_pc_w = pc_plus4_w;
      if (j_c) begin
         next_pc_w = jmp_tgt_w;
      end else if (branch && zero) begin
         next_pc_w = pc_plus4_w + br_off_w;
      end
   end

   // State registers; handshake outputs are flops so reset clears them at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         count_q <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         count_q <= count_d;
         req_q   <= req_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      count_d = count_q;
      req_d   = 1'b0;
      valid_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (advance) begin
               pc_d    = next_pc_w;
               count_d = count_q + XLEN'(1);
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      req_d   = (state_d == S_FETCH);
      valid_d = (state_d == S_HOLD);
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign op_c        = instr_q[XLEN-1 -: OPW];
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_plus4_w;
   assign instr_count = count_q;

endmodule
